// File: rtl/video_capture_window.sv
`timescale 1ns/1ps
// Captures a WIN_WIDTH x WIN_HEIGHT window of a vs/de pixel stream into a RAM write port, raster order.
// Latency: pixel in to write strobe is 2 cycles; one write per clock, RAM cannot backpressure.
module video_capture_window #(
    parameter int COLOR_DEPTH = 8,
    parameter int X_BITS      = 12,
    parameter int Y_BITS      = 12,
    parameter int WIN_X_START = 640,
    parameter int WIN_Y_START = 412,
    parameter int WIN_WIDTH   = 256,
    parameter int WIN_HEIGHT  = 256,
    parameter int ADDR_BITS   = 16
) (
    input  logic                       pix_clk,
    input  logic                       rstn,
    input  logic                       vs_in,
    input  logic                       hs_in,
    input  logic                       de_in,
    input  logic [3*COLOR_DEPTH-1:0]   pixel_in,
    input  logic                       cap_req,
    input  logic                       cont_mode,
    output logic                       wr_en,
    output logic [ADDR_BITS-1:0]       wr_addr,
    output logic [3*COLOR_DEPTH-1:0]   wr_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_err
);

    localparam int PW = 3 * COLOR_DEPTH;
    localparam int XW = X_BITS + 1;
    localparam int YW = Y_BITS + 1;
    localparam logic [XW-1:0] X_LO = XW'(WIN_X_START);
    localparam logic [XW-1:0] X_HI = XW'(WIN_X_START + WIN_WIDTH);
    localparam logic [YW-1:0] Y_LO = YW'(WIN_Y_START);
    localparam logic [YW-1:0] Y_HI = YW'(WIN_Y_START + WIN_HEIGHT);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(WIN_WIDTH * WIN_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  vs_r;
    logic                  vs_rr;
    logic                  de_r;
    logic                  de_rr;
    logic [PW-1:0]         pix_r;
    logic [X_BITS-1:0]     x_q;
    logic [Y_BITS-1:0]     y_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic                  frame_start;
    logic                  line_end;
    logic                  in_win;
    logic                  wr_go;
    logic                  addr_clr;
    logic                  err_go;
    logic                  unused_hs;

    // hs carries no information the counters need; line boundaries come from de.
    assign unused_hs = hs_in;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_r  <= 1'b0;
            vs_rr <= 1'b0;
            de_r  <= 1'b0;
            de_rr <= 1'b0;
            pix_r <= '0;
        end else begin
            vs_r  <= vs_in;
            vs_rr <= vs_r;
            de_r  <= de_in;
            de_rr <= de_r;
            pix_r <= pixel_in;
        end
    end

    assign frame_start = vs_r & ~vs_rr;
    assign line_end    = de_rr & ~de_r;

    // x_q is the column of the pixel currently in pix_r; y_q its row.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (!de_r) begin
                x_q <= '0;
            end else if (!(&x_q)) begin
                x_q <= x_q + 1'b1;
            end
            if (frame_start) begin
                y_q <= '0;
            end else if (line_end && !(&y_q)) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign in_win = de_r
                  && ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI)
                  && ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);

    always_comb begin
        state_next = state;
        wr_go      = 1'b0;
        addr_clr   = 1'b0;
        err_go     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cap_req) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (frame_start) begin
                    state_next = S_CAPTURE;
                    addr_clr   = 1'b1;
                end
            end
            S_CAPTURE: begin
                // A new frame before the window completed: restart on that frame.
                if (frame_start) begin
                    err_go   = 1'b1;
                    addr_clr = 1'b1;
                end else if (in_win) begin
                    wr_go = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = cont_mode ? S_ARMED : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            addr_q <= '0;
        end else begin
            state <= state_next;
            if (addr_clr) begin
                addr_q <= '0;
            end else if (wr_go) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // DONE counts as busy so busy drops together with the frame_done pulse.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en <= wr_go;
            if (wr_go) begin
                wr_addr <= addr_q;
                wr_data <= pix_r;
            end
            busy       <= (state_next != S_IDLE);
            frame_done <= (state == S_DONE);
            frame_err  <= err_go;
        end
    end

endmodule
